delay_calib: RTL

Clocked calibration controller for a delay line built from `delay_one` cells. It launches an edge into the chain and captures the tap vector one clock period later. It converts the thermometer code to a tap count and averages a fixed number of measurements. Upstream of the chain it drives each cell's `i` (first cell) and `rst`. Downstream it consumes the tap outputs and publishes delay-per-clock for tuning logic.

---
 rtl/delay_pkg.sv | 18 +
 rtl/therm_enc.sv | 40 ++++
 rtl/delay_calib.sv | 136 +++++++++++++
 3 files changed

// File: rtl/delay_pkg.sv
// rtl/delay_pkg.sv - shared state encoding and width helper for the delay-line calibrator
package delay_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FLIGHT,
        S_SYNC,
        S_ENCODE,
        S_DONE
    } state_t;

    // Bits needed to hold a leading-ones count of 0..taps inclusive
    function automatic int therm_count(input int taps);
        return $clog2(taps + 1);
    endfunction

endpackage

// File: rtl/therm_enc.sv
// rtl/therm_enc.sv - thermometer code to leading-ones count with ovf/bubble flags
import delay_pkg::*;

module therm_enc #(
    parameter int TAPS = 32,
    parameter int CW   = therm_count(TAPS)
) (
    input  logic [TAPS-1:0] i_therm,
    output logic [CW-1:0]   o_count,
    output logic            o_ovf,
    output logic            o_bubble
);

    logic [CW-1:0] w_cnt;
    logic          w_hole;
    logic          w_bub;

    // Count 1s from bit 0 up to the first 0; any 1 past that hole is a bubble
    always_comb begin
        w_cnt  = '0;
        w_hole = 1'b0;
        w_bub  = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            if (i_therm[i]) begin
                if (w_hole) begin
                    w_bub = 1'b1;
                end else begin
                    w_cnt = w_cnt + CW'(1);
                end
            end else begin
                w_hole = 1'b1;
            end
        end
    end

    assign o_count  = w_cnt;
    assign o_ovf    = &i_therm;
    assign o_bubble = w_bub;

endmodule

// File: rtl/delay_calib.sv
// rtl/delay_calib.sv - launches edges into a delay chain, captures taps and averages the count
import delay_pkg::*;

module delay_calib #(
    parameter  int TAPS     = 32,
    parameter  int AVG_LOG2 = 3,
    localparam int CW       = therm_count(TAPS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TAPS-1:0] taps,
    output logic            chain_i,
    output logic            chain_rst,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   avg,
    output logic            ovf,
    output logic            bubble
);

    localparam int ACCW = CW + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] LAST_SAMPLE = AVG_LOG2'((1 << AVG_LOG2) - 1);

    state_t              r_state;
    logic [TAPS-1:0]     r_tap_q;
    logic [TAPS-1:0]     r_tap_qq;
    logic [ACCW-1:0]     r_acc;
    logic [AVG_LOG2-1:0] r_cnt;
    logic                r_run_ovf;
    logic                r_run_bub;
    logic                r_chain_i;
    logic                r_chain_rst;
    logic                r_busy;
    logic                r_done;
    logic [CW-1:0]       r_avg;
    logic                r_ovf;
    logic                r_bubble;

    logic [CW-1:0]       w_count;
    logic                w_ovf;
    logic                w_bub;
    logic [ACCW-1:0]     w_acc_next;

    // Only the second capture stage feeds the encoder; tap_q may be metastable
    therm_enc #(.TAPS(TAPS), .CW(CW)) u_enc (
        .i_therm  (r_tap_qq),
        .o_count  (w_count),
        .o_ovf    (w_ovf),
        .o_bubble (w_bub)
    );

    assign w_acc_next = r_acc + ACCW'(w_count);

    // Calibration FSM; outputs are set on the edge entering each state so they never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tap_q     <= '0;
            r_tap_qq    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_run_ovf   <= 1'b0;
            r_run_bub   <= 1'b0;
            r_chain_i   <= 1'b0;
            r_chain_rst <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_avg       <= '0;
            r_ovf       <= 1'b0;
            r_bubble    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_run_ovf <= 1'b0;
                    r_run_bub <= 1'b0;
                    if (start) begin
                        r_state <= S_CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state     <= S_FLIGHT;
                    r_chain_rst <= 1'b0;
                    r_chain_i   <= 1'b1;
                end
                S_FLIGHT: begin
                    r_state     <= S_SYNC;
                    r_tap_q     <= taps;
                    r_chain_rst <= 1'b1;
                    r_chain_i   <= 1'b0;
                end
                S_SYNC: begin
                    r_state  <= S_ENCODE;
                    r_tap_qq <= r_tap_q;
                end
                S_ENCODE: begin
                    r_acc     <= w_acc_next;
                    r_run_ovf <= r_run_ovf | w_ovf;
                    r_run_bub <= r_run_bub | w_bub;
                    if (r_cnt == LAST_SAMPLE) begin
                        // Results published together with done on entry to DONE
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_avg    <= w_acc_next[ACCW-1:AVG_LOG2];
                        r_ovf    <= r_run_ovf | w_ovf;
                        r_bubble <= r_run_bub | w_bub;
                    end else begin
                        r_cnt   <= r_cnt + AVG_LOG2'(1);
                        r_state <= S_CLEAR;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign chain_i   = r_chain_i;
    assign chain_rst = r_chain_rst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign avg       = r_avg;
    assign ovf       = r_ovf;
    assign bubble    = r_bubble;

endmodule
